// File: rtl/systolic_drain_if.sv
// Bundle of the drain's data-path signals: the bottom-row psum inputs, the
// active-column size load, and the row output handshake toward the unified
// buffer.
// Signal names match the drain's port names.
// master = array side and buffer consumer; slave = systolic_drain.
interface systolic_drain_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] col_data_in_1;
    logic [DATA_WIDTH-1:0] col_data_in_2;
    logic                  col_valid_in_1;
    logic                  col_valid_in_2;
    logic [15:0]           col_size_in;
    logic                  col_size_valid_in;
    logic [DATA_WIDTH-1:0] row_data_out_1;
    logic [DATA_WIDTH-1:0] row_data_out_2;
    logic                  row_valid_out;
    logic                  row_ready_in;
    logic [15:0]           row_count_out;
    logic                  overflow_out;
    logic                  misalign_out;

    modport master (
        output col_data_in_1, col_data_in_2, col_valid_in_1, col_valid_in_2,
        output col_size_in, col_size_valid_in, row_ready_in,
        input  row_data_out_1, row_data_out_2, row_valid_out,
        input  row_count_out, overflow_out, misalign_out
    );

    modport slave (
        input  col_data_in_1, col_data_in_2, col_valid_in_1, col_valid_in_2,
        input  col_size_in, col_size_valid_in, row_ready_in,
        output row_data_out_1, row_data_out_2, row_valid_out,
        output row_count_out, overflow_out, misalign_out
    );
endinterface

// File: rtl/systolic_drain.sv
// systolic_drain: collects the 2-column systolic array's bottom-row psums.
// Column 1 is delayed one cycle to line up with column 2.
// Whole rows go into a small FIFO that feeds the unified-buffer write port.
// Optional build macro SYSTOLIC_DRAIN_RELU_EN applies ReLU to each enabled
// lane at push time.
// The interface's DATA_WIDTH must equal this module's DATA_WIDTH.
module systolic_drain #(
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 2,
    parameter int unsigned DATA_WIDTH           = 16,
    parameter int unsigned FIFO_DEPTH           = 4
) (
    input  logic             clk,
    input  logic             rst,
    systolic_drain_if.slave  bus
);
    localparam int unsigned SIZE_W = $clog2(SYSTOLIC_ARRAY_WIDTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ROW_W  = 2 * DATA_WIDTH;

    logic [SIZE_W-1:0]     size_q,      size_d;
    logic [DATA_WIDTH-1:0] c1_data_q,   c1_data_d;
    logic                  c1_valid_q,  c1_valid_d;
    logic [ROW_W-1:0]      mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q,      wptr_d;
    logic [PTR_W-1:0]      rptr_q,      rptr_d;
    logic [CNT_W-1:0]      occ_q,       occ_d;
    logic [15:0]           row_count_q, row_count_d;
    logic                  overflow_q,  overflow_d;
    logic                  misalign_q,  misalign_d;

    logic [1:0]            lane_mask;
    logic [1:0]            en_valid;
    logic                  row_all;
    logic                  row_some;
    logic [DATA_WIDTH-1:0] lane0;
    logic [DATA_WIDTH-1:0] lane1;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    function automatic logic [DATA_WIDTH-1:0] lane_xform(input logic [DATA_WIDTH-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return v[DATA_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Alignment: lane enables, row-complete / misalign detection, and the stored row value.
    always_comb begin
        lane_mask = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            lane_mask[k] = (32'(size_q) > k);
        end
        en_valid = {bus.col_valid_in_2, c1_valid_q} & lane_mask;
        row_all  = (lane_mask != '0) && (en_valid == lane_mask);
        row_some = (en_valid != '0) && !row_all;
        lane0    = lane_mask[0] ? lane_xform(c1_data_q)         : '0;
        lane1    = lane_mask[1] ? lane_xform(bus.col_data_in_2) : '0;
    end

    // FIFO control and next-state for every register.
    always_comb begin
        empty   = (occ_q == '0);
        full    = (occ_q == CNT_W'(FIFO_DEPTH));
        pop     = !empty && bus.row_ready_in;
        // When full, a push succeeds only because the same-cycle pop frees a slot.
        push_ok = row_all && (!full || pop);
        drop    = row_all && full && !pop;

        size_d = size_q;
        if (bus.col_size_valid_in) begin
            size_d = (bus.col_size_in > 16'(SYSTOLIC_ARRAY_WIDTH))
                   ? SIZE_W'(SYSTOLIC_ARRAY_WIDTH)
                   : bus.col_size_in[SIZE_W-1:0];
        end

        c1_data_d  = bus.col_data_in_1;
        c1_valid_d = bus.col_valid_in_1;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            mem_d[wptr_q] = {lane1, lane0};
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end

        occ_d = occ_q;
        if (push_ok && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push_ok) begin
            occ_d = occ_q - 1'b1;
        end

        row_count_d = pop ? row_count_q + 16'd1 : row_count_q;
        overflow_d  = overflow_q | drop;
        misalign_d  = misalign_q | row_some;
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q      <= '0;
            c1_data_q   <= '0;
            c1_valid_q  <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            row_count_q <= '0;
            overflow_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            size_q      <= size_d;
            c1_data_q   <= c1_data_d;
            c1_valid_q  <= c1_valid_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            row_count_q <= row_count_d;
            overflow_q  <= overflow_d;
            misalign_q  <= misalign_d;
        end
    end

    // Output drive: head row from storage, zeroed while empty.
    always_comb begin
        bus.row_valid_out  = !empty;
        bus.row_data_out_1 = empty ? '0 : mem_q[rptr_q][DATA_WIDTH-1:0];
        bus.row_data_out_2 = empty ? '0 : mem_q[rptr_q][ROW_W-1:DATA_WIDTH];
        bus.row_count_out  = row_count_q;
        bus.overflow_out   = overflow_q;
        bus.misalign_out   = misalign_q;
    end

    // col_valid_in_1 is consumed via its registered copy only.
    logic unused_ok;
    always_comb unused_ok = ^{bus.col_valid_in_1};
endmodule
